// File: rtl/sent_pkg.sv
// Shared SENT serial-channel definitions: FSM encodings, frame counts and the
// frame-number -> {bit3, bit2} mapping used by the scheduler and its CRC operand builder.
package sent_pkg;

    localparam int unsigned SHORT_FRAMES    = 16;
    localparam int unsigned ENH_FRAMES      = 18;
    localparam int unsigned ENH_SYNC_FRAMES = 6;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_LOAD     = 2'd1;
    localparam state_t ST_CRC_WAIT = 2'd2;
    localparam state_t ST_SEND     = 2'd3;

    // Short message: bit3 marks frame 1, bit2 walks {id, data, crc} MSB first.
    function automatic logic [1:0] short_bits(input logic [4:0] frame, input logic [3:0] id,
                                              input logic [7:0] data, input logic [3:0] crc);
        logic [15:0] sh;
        sh = {id, data, crc} << (frame - 5'd1);
        return {frame == 5'd1, sh[15]};
    endfunction

    function automatic logic [1:0] enh_bits(input logic [4:0] frame, input logic cfg,
                                            input logic [7:0] id8, input logic [11:0] d12,
                                            input logic [15:0] d16, input logic [5:0] crc);
        logic [3:0]  hi, lo, nsh;
        logic [11:0] dat, dsh;
        logic [5:0]  csh;
        logic        b3, b2;
        hi  = cfg ? d16[15:12] : id8[7:4];
        lo  = cfg ? d16[11:8]  : id8[3:0];
        dat = cfg ? d16[11:0]  : d12;
        b3  = 1'b0;
        b2  = 1'b0;
        nsh = '0;
        if (frame >= 5'd1 && frame <= 5'(ENH_SYNC_FRAMES)) begin
            b3  = 1'b1;
            csh = crc << (frame - 5'd1);
            b2  = csh[5];
        end else if (frame >= 5'd7 && frame <= 5'(ENH_FRAMES)) begin
            dsh = dat << (frame - 5'd7);
            b2  = dsh[11];
            if (frame == 5'd8) begin
                b3 = cfg;
            end else if (frame >= 5'd9 && frame <= 5'd12) begin
                nsh = hi << (frame - 5'd9);
                b3  = nsh[3];
            end else if (frame >= 5'd14 && frame <= 5'd17) begin
                nsh = lo << (frame - 5'd14);
                b3  = nsh[3];
            end
        end
        return {b3, b2};
    endfunction

endpackage

// File: rtl/sent_serial_bit_mux.sv
// Combinational frame number -> {bit3, bit2} selector over the latched serial message.
module sent_serial_bit_mux
    import sent_pkg::*;
(
    input  logic        fmt,
    input  logic        cfg,
    input  logic [3:0]  id4,
    input  logic [7:0]  id8,
    input  logic [11:0] d12,
    input  logic [15:0] d16,
    input  logic [7:0]  d_short,
    input  logic [3:0]  crc_s,
    input  logic [5:0]  crc_e,
    input  logic [4:0]  frame,
    output logic [1:0]  bits
);

    always_comb begin
        if (fmt) begin
            bits = enh_bits(frame, cfg, id8, d12, d16, crc_e);
        end else begin
            bits = short_bits(frame, id4, d_short, crc_s);
        end
    end

endmodule

// File: rtl/sent_tx_serial_msg_sched.sv
// SENT slow-channel message scheduler: latches one short/enhanced message, fetches its CRC and
// serves one status nibble pair per frame_req. Optional SENT_MSG_COUNT_EN adds msg_count.
module sent_tx_serial_msg_sched
    import sent_pkg::*;
#(
    parameter int unsigned CRC_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        channel_format,
    input  logic        config_bit,
    input  logic [3:0]  id_4bit,
    input  logic [7:0]  id_8bit,
    input  logic [11:0] data_12bit,
    input  logic [15:0] data_16bit,
    input  logic [7:0]  data_short,
    output logic        crc_req,
    output logic        crc_fmt,
    output logic [11:0] crc_data_short,
    output logic [23:0] crc_data_enh,
    input  logic [3:0]  crc_serial,
    input  logic [5:0]  crc_enhanced,
    input  logic        frame_req,
    output logic [1:0]  status_bits,
    output logic        status_valid,
    output logic        msg_start,
    output logic        msg_done,
    output logic        busy
`ifdef SENT_MSG_COUNT_EN
    ,
    output logic [7:0]  msg_count
`endif
);

    state_t      state_q, state_d;
    logic        fmt_q, cfg_q;
    logic [3:0]  id4_q;
    logic [7:0]  id8_q, ds_q;
    logic [11:0] d12_q;
    logic [15:0] d16_q;
    logic [3:0]  crc_s_q;
    logic [5:0]  crc_e_q;
    logic [4:0]  frame_cnt_q, frame_nxt, last_frame;
    logic [1:0]  wait_cnt_q;
    logic [1:0]  status_bits_q, mux_bits;
    logic        crc_req_q, status_valid_q, msg_start_q, msg_done_q;
    logic        crc_done, serve, is_last;
    logic [23:0] enh_acc;

    assign last_frame = fmt_q ? 5'(ENH_FRAMES) : 5'(SHORT_FRAMES);
    assign crc_done   = (state_q == ST_CRC_WAIT) && (wait_cnt_q == 2'(CRC_LAT));
    // A request landing on the CRC_WAIT -> SEND edge is served as frame 1 with the fresh CRC.
    assign serve      = frame_req && ((state_q == ST_SEND) || crc_done);
    assign frame_nxt  = (state_q == ST_SEND) ? frame_cnt_q + 5'd1 : 5'd1;
    assign is_last    = serve && (frame_nxt == last_frame);

    sent_serial_bit_mux u_bit_mux (
        .fmt     (fmt_q),
        .cfg     (cfg_q),
        .id4     (id4_q),
        .id8     (id8_q),
        .d12     (d12_q),
        .d16     (d16_q),
        .d_short (ds_q),
        .crc_s   (crc_done ? crc_serial : crc_s_q),
        .crc_e   (crc_done ? crc_enhanced : crc_e_q),
        .frame   (frame_nxt),
        .bits    (mux_bits)
    );

    always_comb begin
        enh_acc = '0;
        for (int f = 7; f <= int'(ENH_FRAMES); f++) begin
            enh_acc = {enh_acc[21:0], enh_bits(5'(f), cfg_q, id8_q, d12_q, d16_q, 6'd0)};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (enable) state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_CRC_WAIT;
            ST_CRC_WAIT: if (crc_done) state_d = ST_SEND;
            ST_SEND:     if (is_last) state_d = enable ? ST_LOAD : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            {fmt_q, cfg_q} <= '0;
            id4_q          <= '0;
            id8_q          <= '0;
            ds_q           <= '0;
            d12_q          <= '0;
            d16_q          <= '0;
            crc_s_q        <= '0;
            crc_e_q        <= '0;
            frame_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            status_bits_q  <= '0;
            crc_req_q      <= 1'b0;
            status_valid_q <= 1'b0;
            msg_start_q    <= 1'b0;
            msg_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            crc_req_q      <= (state_q == ST_LOAD);
            status_valid_q <= frame_req;
            msg_start_q    <= serve && (frame_nxt == 5'd1);
            msg_done_q     <= is_last;
            if (state_q == ST_LOAD) begin
                fmt_q       <= channel_format;
                cfg_q       <= config_bit;
                id4_q       <= id_4bit;
                id8_q       <= id_8bit;
                ds_q        <= data_short;
                d12_q       <= data_12bit;
                d16_q       <= data_16bit;
                frame_cnt_q <= '0;
                wait_cnt_q  <= '0;
            end else if (state_q == ST_CRC_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 2'd1;
            end
            if (crc_done) begin
                crc_s_q <= crc_serial;
                crc_e_q <= crc_enhanced;
            end
            if (serve) begin
                frame_cnt_q   <= frame_nxt;
                status_bits_q <= mux_bits;
            end else if (frame_req || state_q == ST_IDLE) begin
                status_bits_q <= 2'b00;
            end
        end
    end

    assign crc_req        = crc_req_q;
    assign crc_fmt        = fmt_q;
    assign crc_data_short = {id4_q, ds_q};
    assign crc_data_enh   = enh_acc;
    assign status_bits    = status_bits_q;
    assign status_valid   = status_valid_q;
    assign msg_start      = msg_start_q;
    assign msg_done       = msg_done_q;
    assign busy           = (state_q != ST_IDLE);

`ifdef SENT_MSG_COUNT_EN
    logic [7:0] msg_count_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_count_q <= '0;
        end else if (is_last) begin
            msg_count_q <= msg_count_q + 8'd1;
        end
    end
    assign msg_count = msg_count_q;
`endif

endmodule

// File: tb/tb_sent_tx_serial_msg_sched.sv
// Directed bench for sent_tx_serial_msg_sched: message table plus hand-written corner sequences.
module tb_sent_tx_serial_msg_sched;

    logic        clk = 1'b0;
    logic        reset, enable, channel_format, config_bit, frame_req;
    logic [3:0]  id_4bit, crc_serial;
    logic [7:0]  id_8bit, data_short;
    logic [11:0] data_12bit, crc_data_short;
    logic [15:0] data_16bit;
    logic [5:0]  crc_enhanced;
    logic        crc_req, crc_fmt, status_valid, msg_start, msg_done, busy;
    logic [23:0] crc_data_enh;
    logic [1:0]  status_bits;
`ifdef SENT_MSG_COUNT_EN
    logic [7:0]  msg_count;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sent_tx_serial_msg_sched #(.CRC_LAT(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .channel_format (channel_format),
        .config_bit     (config_bit),
        .id_4bit        (id_4bit),
        .id_8bit        (id_8bit),
        .data_12bit     (data_12bit),
        .data_16bit     (data_16bit),
        .data_short     (data_short),
        .crc_req        (crc_req),
        .crc_fmt        (crc_fmt),
        .crc_data_short (crc_data_short),
        .crc_data_enh   (crc_data_enh),
        .crc_serial     (crc_serial),
        .crc_enhanced   (crc_enhanced),
        .frame_req      (frame_req),
        .status_bits    (status_bits),
        .status_valid   (status_valid),
        .msg_start      (msg_start),
        .msg_done       (msg_done),
        .busy           (busy)
`ifdef SENT_MSG_COUNT_EN
        ,
        .msg_count      (msg_count)
`endif
    );

    // Expected bit3/bit2 streams are frame 1 at bit 17; exp_crc is the CRC operand for fmt.
    typedef struct {
        logic        fmt;
        logic        cfg;
        logic [3:0]  id4;
        logic [7:0]  id8;
        logic [11:0] d12;
        logic [15:0] d16;
        logic [7:0]  ds;
        logic [3:0]  crc_s;
        logic [5:0]  crc_e;
        logic [17:0] exp_b3;
        logic [17:0] exp_b2;
        logic [23:0] exp_crc;
    } msg_vec_t;

    msg_vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int i);
        channel_format = vecs[i].fmt;
        config_bit     = vecs[i].cfg;
        id_4bit        = vecs[i].id4;
        id_8bit        = vecs[i].id8;
        data_12bit     = vecs[i].d12;
        data_16bit     = vecs[i].d16;
        data_short     = vecs[i].ds;
        crc_serial     = vecs[i].crc_s;
        crc_enhanced   = vecs[i].crc_e;
    endtask

    task automatic wait_crc(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (crc_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("crc_req_seen", 32'(ok), 32'd1);
    endtask

    task automatic serve_check(input int n, input int nf, input logic [17:0] b3,
                               input logic [17:0] b2);
        logic [17:0] s3, s2;
        logic [4:0]  exp;
        s3 = b3 << (n - 1);
        s2 = b2 << (n - 1);
        exp = {1'b1, n == 1, n == nf, s3[17], s2[17]};
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check($sformatf("frame%0d", n), 32'({status_valid, msg_start, msg_done, status_bits}),
              32'(exp));
        tick();
    endtask

    task automatic check_idle_req(input string name);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check(name, 32'({status_valid, msg_start, msg_done, status_bits, busy}), 32'b100000);
        tick();
    endtask

    initial begin
        bit ok;
        int nf, pulses;
        vecs[0] = '{fmt: 1'b0, cfg: 1'b0, id4: 4'hA, id8: 8'h00, d12: 12'h000, d16: 16'h0000,
                    ds: 8'h5C, crc_s: 4'h3, crc_e: 6'h00, exp_b3: {16'h8000, 2'b00},
                    exp_b2: {16'hA5C3, 2'b00}, exp_crc: 24'h000A5C};
        vecs[1] = '{fmt: 1'b1, cfg: 1'b0, id4: 4'h0, id8: 8'h5A, d12: 12'hABC, d16: 16'h0000,
                    ds: 8'h00, crc_s: 4'h0, crc_e: 6'h2D, exp_b3: 18'b111111_0_0_0101_0_1010_0,
                    exp_b2: 18'b101101_1010_1011_1100, exp_crc: 24'h466770};
        vecs[2] = '{fmt: 1'b1, cfg: 1'b1, id4: 4'h0, id8: 8'hFF, d12: 12'h000, d16: 16'h3C96,
                    ds: 8'h00, crc_s: 4'h0, crc_e: 6'h12, exp_b3: 18'b111111_0_1_0011_0_1100_0,
                    exp_b2: 18'b010010_1100_1001_0110, exp_crc: 24'h70E394};
        vecs[3] = '{fmt: 1'b0, cfg: 1'b0, id4: 4'h3, id8: 8'h00, d12: 12'h000, d16: 16'h0000,
                    ds: 8'hF0, crc_s: 4'hE, crc_e: 6'h00, exp_b3: {16'h8000, 2'b00},
                    exp_b2: {16'h3F0E, 2'b00}, exp_crc: 24'h0003F0};

        reset = 1'b1;
        enable = 1'b0;
        frame_req = 1'b0;
        apply(0);
        repeat (3) tick();
        reset = 1'b0;
        check("reset_ctrl", 32'({status_bits, status_valid, msg_start, msg_done, busy, crc_req,
                                 crc_fmt}), 32'd0);
        check("reset_data", 32'({crc_data_short, crc_data_enh}), 32'd0);
        check_idle_req("idle_req");

        for (int i = 0; i < 4; i++) begin
            apply(i);
            nf = vecs[i].fmt ? 18 : 16;
            enable = 1'b1;
            wait_crc(ok);
            check($sformatf("v%0d_crc_fmt", i), 32'(crc_fmt), 32'(vecs[i].fmt));
            if (vecs[i].fmt) check($sformatf("v%0d_crc_enh", i), 32'(crc_data_enh),
                                   32'(vecs[i].exp_crc));
            else check($sformatf("v%0d_crc_short", i), 32'(crc_data_short),
                       32'(vecs[i].exp_crc));
            enable = 1'b0;
            tick();
            tick();
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            for (int n = 1; n <= nf; n++) serve_check(n, nf, vecs[i].exp_b3, vecs[i].exp_b2);
            check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end

        // Enable dropped at frame 5: message completes, then no new message starts.
        apply(0);
        enable = 1'b1;
        wait_crc(ok);
        tick();
        tick();
        for (int n = 1; n <= 16; n++) begin
            if (n == 5) enable = 1'b0;
            serve_check(n, 16, vecs[0].exp_b3, vecs[0].exp_b2);
        end
        check("drop_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (crc_req) pulses++;
        end
        check("drop_no_reload", 32'(pulses), 32'd0);
        check_idle_req("drop_idle_req");

        // Reset at enhanced frame 10, then a clean restart of the same message.
        apply(1);
        enable = 1'b1;
        wait_crc(ok);
        enable = 1'b0;
        tick();
        tick();
        for (int n = 1; n <= 10; n++) serve_check(n, 18, vecs[1].exp_b3, vecs[1].exp_b2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ctrl", 32'({status_bits, status_valid, msg_start, msg_done, busy, crc_req,
                                  crc_fmt}), 32'd0);
        check("midrst_data", 32'({crc_data_short, crc_data_enh}), 32'd0);
        enable = 1'b1;
        wait_crc(ok);
        check("restart_crc_enh", 32'(crc_data_enh), 32'h466770);
        enable = 1'b0;
        tick();
        tick();
        for (int n = 1; n <= 18; n++) serve_check(n, 18, vecs[1].exp_b3, vecs[1].exp_b2);

        // Back-to-back with data change mid-message; second message's first request lands
        // on the CRC_WAIT -> SEND edge.
        apply(0);
        enable = 1'b1;
        wait_crc(ok);
        check("b2b_crc1", 32'(crc_data_short), 32'hA5C);
        tick();
        tick();
        for (int n = 1; n <= 16; n++) begin
            if (n == 6) data_short = 8'h00;
            serve_check(n, 16, vecs[0].exp_b3, vecs[0].exp_b2);
        end
        wait_crc(ok);
        check("b2b_crc2", 32'(crc_data_short), 32'hA00);
        tick();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check("b2b_edge_frame1", 32'({status_valid, msg_start, msg_done, status_bits}),
              32'b11011);
        tick();
        enable = 1'b0;
        for (int n = 2; n <= 16; n++) serve_check(n, 16, {16'h8000, 2'b00}, {16'hA003, 2'b00});
        check("b2b_idle", 32'(busy), 32'd0);

`ifdef SENT_MSG_COUNT_EN
        begin
            logic [7:0] c0;
            c0 = msg_count;
            apply(0);
            enable = 1'b1;
            for (int m = 0; m < 257; m++) begin
                wait_crc(ok);
                if (m == 256) enable = 1'b0;
                tick();
                tick();
                for (int n = 0; n < 16; n++) begin
                    frame_req = 1'b1;
                    tick();
                    frame_req = 1'b0;
                    tick();
                end
            end
            check("msg_count_wrap", 32'(msg_count), 32'(c0 + 8'd1));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
